// File: rtl/axi_4_master_burst_controller.sv
// Initiator-side AXI4 INCR burst engine: one VLSU load/store request becomes
// one AR+R or AW+W+B transaction, with done/error status pulsed at the end.
module axi_4_master_burst_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_data_valid,
  output logic              st_data_pop,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_data_valid,
  output logic              ld_done,
  output logic              st_done,
  output logic              ld_err,
  output logic              st_err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic              m_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [LEN_W-1:0]  m_awlen,
  output logic              m_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              s_wready,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              m_bready,
  output logic [2:0]        dbg_state_o
);

  // Handshakes: a transfer happens on any posedge where valid & ready are both
  // high; a raised valid holds (with stable payload) until that edge.
  typedef enum logic [2:0] {M_IDLE, M_AR, M_R, M_WR, M_B} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
  logic              aw_done_q, aw_done_d;
  logic              rerr_q, rerr_d;
  logic              ld_done_q, ld_done_d, ld_err_q, ld_err_d;
  logic              st_done_q, st_done_d, st_err_q, st_err_d;
  logic [LEN_W:0]    len_ext;
  logic              w_remain, w_hs, aw_ok, w_ok;

  assign len_ext     = {1'b0, len_q};
  assign m_araddr    = addr_q;
  assign m_arlen     = len_q;
  assign m_awaddr    = addr_q;
  assign m_awlen     = len_q;
  assign m_wdata     = st_data;
  assign ld_data     = s_rdata;
  assign ld_done     = ld_done_q;
  assign ld_err      = ld_err_q;
  assign st_done     = st_done_q;
  assign st_err      = st_err_q;
  assign busy        = (state_q != M_IDLE);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= M_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      aw_done_q  <= 1'b0;
      rerr_q     <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
      st_done_q  <= 1'b0;
      st_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      aw_done_q  <= aw_done_d;
      rerr_q     <= rerr_d;
      ld_done_q  <= ld_done_d;
      ld_err_q   <= ld_err_d;
      st_done_q  <= st_done_d;
      st_err_q   <= st_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    aw_done_d     = aw_done_q;
    rerr_d        = rerr_q;
    ld_done_d     = 1'b0;
    ld_err_d      = 1'b0;
    st_done_d     = 1'b0;
    st_err_d      = 1'b0;
    m_arvalid     = 1'b0;
    m_rready      = 1'b0;
    ld_data_valid = 1'b0;
    m_awvalid     = 1'b0;
    m_wvalid      = 1'b0;
    m_wlast       = 1'b0;
    st_data_pop   = 1'b0;
    m_bready      = 1'b0;
    w_remain      = 1'b0;
    w_hs          = 1'b0;
    aw_ok         = 1'b0;
    w_ok          = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (ld_req || st_req) begin
          addr_d     = req_addr;
          len_d      = req_len;
          beat_cnt_d = '0;
          aw_done_d  = 1'b0;
          rerr_d     = 1'b0;
          state_d    = ld_req ? M_AR : M_WR;
        end
      end
      M_AR: begin
        m_arvalid = 1'b1;
        if (s_arready) state_d = M_R;
      end
      M_R: begin
        m_rready      = 1'b1;
        ld_data_valid = s_rvalid;
        if (s_rvalid) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (s_rresp != 2'b00) rerr_d = 1'b1;
          if (s_rlast) begin
            // beat_cnt_q counts earlier beats, so the last beat must see len
            state_d   = M_IDLE;
            ld_done_d = 1'b1;
            ld_err_d  = rerr_q | (s_rresp != 2'b00) | (beat_cnt_q != len_ext);
          end
        end
      end
      M_WR: begin
        m_awvalid   = !aw_done_q;
        w_remain    = (beat_cnt_q <= len_ext);
        m_wvalid    = st_data_valid & w_remain;
        m_wlast     = (beat_cnt_q == len_ext);
        w_hs        = m_wvalid & s_wready;
        st_data_pop = w_hs;
        if (w_hs) beat_cnt_d = beat_cnt_q + 1'b1;
        if (m_awvalid && s_awready) aw_done_d = 1'b1;
        aw_ok = aw_done_q | s_awready;
        w_ok  = !w_remain | (w_hs & m_wlast);
        if (aw_ok && w_ok) state_d = M_B;
      end
      M_B: begin
        m_bready = 1'b1;
        if (s_bvalid) begin
          state_d   = M_IDLE;
          st_done_d = 1'b1;
          st_err_d  = (s_bresp != 2'b00);
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_4_master_burst_controller.sv
// Bench for axi_4_master_burst_controller: directed burst table, randomized
// bursts scored against a transaction-level model, and a mid-burst reset.
module tb_axi_4_master_burst_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, st_req;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [31:0] st_data;
  logic        st_data_valid, st_data_pop;
  logic [31:0] ld_data;
  logic        ld_data_valid, ld_done, st_done, ld_err, st_err, busy;
  logic [31:0] m_araddr, m_awaddr, m_wdata, s_rdata;
  logic [7:0]  m_arlen, m_awlen;
  logic        m_arvalid, s_arready, s_rlast, s_rvalid, m_rready;
  logic        m_awvalid, s_awready, m_wlast, m_wvalid, s_wready;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_bvalid, m_bready;
  logic [2:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] data_q[$];

  axi_4_master_burst_controller #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .ld_req(ld_req), .st_req(st_req),
    .req_addr(req_addr), .req_len(req_len), .st_data(st_data),
    .st_data_valid(st_data_valid), .st_data_pop(st_data_pop),
    .ld_data(ld_data), .ld_data_valid(ld_data_valid), .ld_done(ld_done),
    .st_done(st_done), .ld_err(ld_err), .st_err(st_err), .busy(busy),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid),
    .s_awready(s_awready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .s_wready(s_wready), .s_bresp(s_bresp),
    .s_bvalid(s_bvalid), .m_bready(m_bready), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    bit          is_ld;
    logic [31:0] addr;
    logic [7:0]  len;
    int          rlast_beat;
    int          err_beat;
    int          dly;
    logic [1:0]  bresp;
    bit          both;
    bit          exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Read error rule: any non-OKAY beat up to rlast, or rlast on the wrong beat.
  function automatic bit model_rd_err(input int len, input int rlast_beat, input int err_beat);
    return (err_beat >= 1 && err_beat <= rlast_beat) || (rlast_beat != len + 1);
  endfunction

  task automatic idle_inputs();
    ld_req = 0; st_req = 0; st_data_valid = 0; s_arready = 0; s_rvalid = 0;
    s_rlast = 0; s_rresp = 0; s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input int rlast_beat,
                          input int err_beat, input int ar_delay, input bit st_too,
                          input bit gaps, input bit exp_err);
    int b;
    logic [31:0] d;
    @(negedge clk);
    ld_req = 1; st_req = st_too; req_addr = addr; req_len = len;
    #1 chk("rd_idle_busy", busy, 0);
    @(negedge clk);
    ld_req = 0; req_addr = $urandom; req_len = 8'($urandom);
    for (int i = 0; i <= ar_delay; i++) begin
      if (i > 0) @(negedge clk);
      s_arready = (i == ar_delay);
      #1;
      chk("arvalid", m_arvalid, 1);
      chk("araddr", m_araddr, addr);
      chk("arlen", m_arlen, len);
      if (st_too) chk("aw_while_rd", m_awvalid, 0);
    end
    b = 1;
    while (b <= rlast_beat) begin
      @(negedge clk);
      s_arready = 0;
      if (gaps && $urandom_range(3) == 0) begin
        s_rvalid = 0;
        #1 chk("rd_gap_valid", ld_data_valid, 0);
        chk("rd_gap_rready", m_rready, 1);
      end else begin
        d = $urandom;
        s_rvalid = 1; s_rdata = d; s_rresp = (b == err_beat) ? 2'b10 : 2'b00;
        s_rlast = (b == rlast_beat);
        #1;
        chk("rready", m_rready, 1);
        chk("ld_data_valid", ld_data_valid, 1);
        chk("ld_data", ld_data, d);
        chk("arvalid_off", m_arvalid, 0);
        if (st_too) chk("aw_while_rd", m_awvalid, 0);
        b++;
      end
    end
    @(negedge clk);
    s_rvalid = 0; s_rlast = 0; s_rresp = 0; st_req = 0;
    #1;
    chk("ld_done", ld_done, 1);
    chk("ld_err", ld_err, exp_err);
    chk("rd_end_busy", busy, 0);
    chk("rd_end_rready", m_rready, 0);
    @(negedge clk);
    #1;
    chk("ld_done_pulse", ld_done, 0);
    chk("rd_after_busy", busy, 0);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input int aw_delay,
                           input logic [1:0] bresp, input bit wr_rand, input bit exp_err);
    int cyc, sent, d;
    bit aw_hs, presenting, exp_pop;
    exp_q.delete(); data_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      d = $urandom;
      data_q.push_back(d);
      exp_q.push_back(d);
    end
    @(negedge clk);
    st_req = 1; req_addr = addr; req_len = len;
    #1 chk("wr_idle_busy", busy, 0);
    cyc = 0; sent = 0; aw_hs = 0; presenting = 0;
    while (!(aw_hs && sent == int'(len) + 1)) begin
      @(negedge clk);
      st_req = 0; req_addr = $urandom; req_len = 8'($urandom);
      cyc++;
      if (cyc > 2000) begin
        chk("wr_timeout", 1, 0);
        break;
      end
      if (!presenting && data_q.size() > 0 && (!wr_rand || $urandom_range(3) != 0)) presenting = 1;
      st_data_valid = presenting;
      st_data = presenting ? data_q[0] : $urandom;
      s_awready = (cyc > aw_delay);
      s_wready = wr_rand ? 1'($urandom_range(1)) : 1'b1;
      #1;
      chk("bready_early", m_bready, 0);
      chk("awvalid", m_awvalid, !aw_hs);
      if (!aw_hs) begin
        chk("awaddr", m_awaddr, addr);
        chk("awlen", m_awlen, len);
      end
      chk("wvalid", m_wvalid, presenting);
      exp_pop = presenting && s_wready;
      chk("st_data_pop", st_data_pop, exp_pop);
      if (exp_pop) begin
        chk("wdata", m_wdata, exp_q.pop_front());
        chk("wlast", m_wlast, exp_q.size() == 0);
        void'(data_q.pop_front());
        presenting = 0;
        sent++;
      end
      if (!aw_hs && s_awready) aw_hs = 1;
    end
    d = $urandom_range(2);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      st_data_valid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
      #1 chk("bready_wait", m_bready, 1);
      chk("b_awvalid", m_awvalid, 0);
    end
    @(negedge clk);
    st_data_valid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = bresp;
    #1 chk("bready", m_bready, 1);
    @(negedge clk);
    s_bvalid = 0; s_bresp = 0;
    #1;
    chk("st_done", st_done, 1);
    chk("st_err", st_err, exp_err);
    chk("wr_end_busy", busy, 0);
    @(negedge clk);
    #1 chk("st_done_pulse", st_done, 0);
  endtask

  initial begin
    int len, rl, eb;
    bit is_ld;
    logic [1:0] br;
    idle_inputs();
    req_addr = 0; req_len = 0; st_data = 0; s_rdata = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_done", {ld_done, st_done, ld_err, st_err}, 0);
    chk("rst_pop", st_data_pop, 0);

    //                 ld  addr          len  rlast err dly bresp both err
    tbl[0] = '{1'b1, 32'h0000_0100, 8'd3,   4,   0,  0, 2'b00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0200, 8'd1,   0,   0,  3, 2'b00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0300, 8'd2,   0,   0,  0, 2'b10, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'h0000_0400, 8'd3,   2,   0,  0, 2'b00, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0500, 8'd2,   3,   0,  1, 2'b00, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0600, 8'd0,   1,   1,  0, 2'b00, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h0000_0700, 8'd0,   0,   0,  0, 2'b00, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'h0000_1000, 8'd255, 256, 0,  0, 2'b00, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 32'h0000_2000, 8'd7,   0,   0, 10, 2'b11, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 32'h0000_3000, 8'd5,   0,   0,  0, 2'b00, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_ld)
        run_read(tbl[i].addr, tbl[i].len, tbl[i].rlast_beat, tbl[i].err_beat,
                 tbl[i].dly, tbl[i].both, 1'b0, tbl[i].exp_err);
      else
        run_write(tbl[i].addr, tbl[i].len, tbl[i].dly, tbl[i].bresp, 1'b0, tbl[i].exp_err);
    end

    for (int i = 0; i < 24; i++) begin
      is_ld = 1'($urandom_range(1));
      len = $urandom_range(15);
      if (is_ld) begin
        rl = ($urandom_range(1) == 1) ? len + 1 : $urandom_range(len + 2, 1);
        eb = ($urandom_range(2) == 0) ? $urandom_range(rl, 1) : 0;
        run_read($urandom, 8'(len), rl, eb, $urandom_range(3), 1'($urandom_range(1)),
                 1'b1, model_rd_err(len, rl, eb));
      end else begin
        br = 2'($urandom_range(3));
        run_write($urandom, 8'(len), $urandom_range(len + 3), br, 1'b1, br != 2'b00);
      end
    end

    // reset during the second R beat abandons the burst silently
    @(negedge clk);
    ld_req = 1; req_addr = 32'h80; req_len = 8'd3;
    @(negedge clk);
    ld_req = 0; s_arready = 1;
    @(negedge clk);
    s_arready = 0; s_rvalid = 1; s_rdata = 32'h11;
    @(negedge clk);
    s_rdata = 32'h22; reset = 1;
    @(negedge clk);
    reset = 0; s_rvalid = 0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_rready", m_rready, 0);
    chk("mr_arvalid", m_arvalid, 0);
    chk("mr_ldvalid", ld_data_valid, 0);
    chk("mr_done", ld_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("mr_no_done", ld_done, 0);
    end
    run_read(32'h90, 8'd1, 2, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
